// File: rtl/t05_bus_pkg.sv
// Shared types for the t05 bus responder: FSM state encoding, operation
// kind and bus word geometry.
package t05_bus_pkg;

  // Bytes per bus word; each byte has its own enable bit in sel_i.
  localparam int WORD_BYTES = 4;

  // Responder handshake states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } resp_state_t;

  // Operation latched at request acceptance.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } resp_op_t;

endpackage

// File: rtl/t05_resp_mem.sv
// Word RAM for the t05 bus responder: one write port with per-byte enables
// and one read port with a registered output. Storage is split into one
// byte-wide array per lane so each lane infers a plain block RAM.
// Contents are never reset.
module t05_resp_mem
  import t05_bus_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;

      // Byte lane: conditional write, unconditional registered read.
      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[waddr] <= wdata[8*gi +: 8];
        end
        lane_rd_reg <= lane_mem[raddr];
      end

      assign rdata[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: rtl/t05_bus_responder.sv
// Bus-side responder for the t05 CPU request interface.
// Accepts one level-held read/write request at a time, waits WAIT_CYCLES,
// performs the access on a local byte-enabled RAM, then drops busy_o and
// waits for the initiator to release its request before accepting another.
// Optional feature macro: T05_BUS_RESPONDER_ERR_EN enables err_o reporting
// of out-of-window accesses; without it err_o is constant 0.
module t05_bus_responder
  import t05_bus_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic        busy_o,
  output logic [31:0] cpu_dat_o,
  output logic        err_o
);

  localparam int IDX_HI = DEPTH_LOG2 + 1;
  localparam int TAG_LO = DEPTH_LOG2 + 2;

  // Latched request
  logic [31:2]           adr_reg;
  logic [WORD_BYTES-1:0] sel_reg;
  logic [31:0]           wdat_reg;
  resp_op_t              op_reg;

  // Control / outputs
  resp_state_t state_reg;
  logic [3:0]  cnt_reg;
  logic        busy_reg;
  logic [31:0] rdat_reg;

  // Memory interface
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           mem_rdata;
  logic                  mem_we;
  logic                  in_window;
  logic                  access_go;

  // Byte-offset bits of the address carry no meaning for a word target.
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^adr_i[1:0];

  // The window tag compare gates the memory operation regardless of
  // whether err_o reporting is built in.
  assign in_window = (adr_reg[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);

  // Final ACCESS cycle: the operation happens here.
  assign access_go = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  // In IDLE the RAM is addressed straight from the bus so that the word is
  // already in the read register on the first ACCESS cycle, which keeps
  // WAIT_CYCLES=0 correct. Afterwards the latched address holds it steady.
  assign rd_idx = (state_reg == IDLE) ? adr_i[IDX_HI:2] : adr_reg[IDX_HI:2];
  assign wr_idx = adr_reg[IDX_HI:2];
  assign mem_we = access_go && (op_reg == OP_WRITE) && in_window;

  t05_resp_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (sel_reg),
    .waddr (wr_idx),
    .wdata (wdat_reg),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  // Request latch: captured only when a new request is accepted in IDLE.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      adr_reg  <= '0;
      sel_reg  <= '0;
      wdat_reg <= '0;
      op_reg   <= OP_READ;
    end else if ((state_reg == IDLE) && (read_i || write_i)) begin
      adr_reg  <= adr_i[31:2];
      sel_reg  <= sel_i;
      wdat_reg <= cpu_dat_i;
      op_reg   <= write_i ? OP_WRITE : OP_READ;
    end
  end

  // Handshake FSM with wait counter and registered busy/read-data outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
      rdat_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read_i || write_i) begin
            busy_reg  <= 1'b1;
            cnt_reg   <= 4'(WAIT_CYCLES);
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            // Reads outside the window return zero; writes are gated above.
            if (op_reg == OP_READ) begin
              rdat_reg <= in_window ? mem_rdata : 32'h0;
            end
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= RELEASE;
        end
        RELEASE: begin
          // Swallow the request the initiator still holds after busy falls.
          if (!read_i && !write_i) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_reg;
  assign cpu_dat_o = rdat_reg;

`ifdef T05_BUS_RESPONDER_ERR_EN
  logic err_reg;

  // Error flag: cleared on acceptance, raised alongside busy falling.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      err_reg <= 1'b0;
    end else if ((state_reg == IDLE) && (read_i || write_i)) begin
      err_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      err_reg <= !in_window;
    end
  end

  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule
